// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm_if
// Brief    : Decode/flag inputs and datapath control outputs of the
//            multi-cycle RV32I main control FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_ctrl_fsm_if #(
    parameter int ALUCTRL_W = 4
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero_flag;
    logic                 lt_flag;
    logic                 ltu_flag;
    logic                 mem_rdy;
    logic                 mem_req;
    logic                 pc_write;
    logic                 ir_write;
    logic                 reg_write;
    logic                 mem_write;
    logic                 adr_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [2:0]           imm_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 halted;

    // Controller side
    modport master (
        input  opcode, funct3, funct7_5, zero_flag, lt_flag, ltu_flag, mem_rdy,
        output mem_req, pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, halted
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct3, funct7_5, zero_flag, lt_flag, ltu_flag, mem_rdy,
        input  mem_req, pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, halted
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Main control FSM of the multi-cycle RV32I core with variable
//            latency memory handshake and memory timeout.
//            Option macro MC_CTRL_TRAP_EN: unknown opcodes halt the core.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 255,
    parameter int ALUCTRL_W     = 4
) (
    input  logic              clk,
    input  logic              rstn,
    mc_ctrl_fsm_if.master     bus
);
    localparam logic [4:0] c_ST_RST    = 5'd0;
    localparam logic [4:0] c_ST_FETCH  = 5'd1;
    localparam logic [4:0] c_ST_DECODE = 5'd2;
    localparam logic [4:0] c_ST_MEMADR = 5'd3;
    localparam logic [4:0] c_ST_MEMRD  = 5'd4;
    localparam logic [4:0] c_ST_MEMWB  = 5'd5;
    localparam logic [4:0] c_ST_MEMWR  = 5'd6;
    localparam logic [4:0] c_ST_EXR    = 5'd7;
    localparam logic [4:0] c_ST_EXI    = 5'd8;
    localparam logic [4:0] c_ST_ALUWB  = 5'd9;
    localparam logic [4:0] c_ST_BR     = 5'd10;
    localparam logic [4:0] c_ST_JAL    = 5'd11;
    localparam logic [4:0] c_ST_JALR   = 5'd12;
    localparam logic [4:0] c_ST_JALR2  = 5'd13;
    localparam logic [4:0] c_ST_LUI    = 5'd14;
    localparam logic [4:0] c_ST_AUIPC  = 5'd15;
    localparam logic [4:0] c_ST_HALT   = 5'd16;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [1:0] c_SA_PC   = 2'b00;
    localparam logic [1:0] c_SA_OLD  = 2'b01;
    localparam logic [1:0] c_SA_A    = 2'b10;
    localparam logic [1:0] c_SA_ZERO = 2'b11;
    localparam logic [1:0] c_SB_RD2  = 2'b00;
    localparam logic [1:0] c_SB_IMM  = 2'b01;
    localparam logic [1:0] c_SB_FOUR = 2'b10;
    localparam logic [1:0] c_RS_ALUOUT = 2'b00;
    localparam logic [1:0] c_RS_DATA   = 2'b01;
    localparam logic [1:0] c_RS_ALURES = 2'b10;
    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_U = 3'b100;

    localparam logic [ALUCTRL_W-1:0] c_ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] c_ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] c_ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] c_ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLTU = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SRL  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SRA  = ALUCTRL_W'(9);

    // Counter only needs to hold 0..MEM_TIMEOUT-1 (wait cycles before the last chance)
    localparam int              c_CW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [4:0]           r_state;
    logic [4:0]           w_next;
    logic [c_CW-1:0]      r_cnt;
    logic                 w_rdy;
    logic                 w_mem_st;
    logic                 w_tmo;
    logic                 w_taken;
    logic                 w_mem_req, w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_adr_src;
    logic [1:0]           w_alu_src_a, w_alu_src_b, w_result_src;
    logic [2:0]           w_imm_src;
    logic [ALUCTRL_W-1:0] w_alu_ctrl;

    function automatic logic [ALUCTRL_W-1:0] f_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu_op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  f_alu_op = c_ALU_SLL;
            3'b010:  f_alu_op = c_ALU_SLT;
            3'b011:  f_alu_op = c_ALU_SLTU;
            3'b100:  f_alu_op = c_ALU_XOR;
            3'b101:  f_alu_op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  f_alu_op = c_ALU_OR;
            default: f_alu_op = c_ALU_AND;
        endcase
    endfunction

    assign w_rdy    = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_rdy;
    assign w_mem_st = (r_state == c_ST_FETCH) || (r_state == c_ST_MEMRD) || (r_state == c_ST_MEMWR);
    // A ready in the last allowed cycle still completes the access
    assign w_tmo    = (MEM_TIMEOUT != 0) && w_mem_st && !w_rdy && (r_cnt == c_TMO_LAST);

    always_comb begin
        case (bus.funct3)
            3'b000:  w_taken =  bus.zero_flag;
            3'b001:  w_taken = !bus.zero_flag;
            3'b100:  w_taken =  bus.lt_flag;
            3'b101:  w_taken = !bus.lt_flag;
            3'b110:  w_taken =  bus.ltu_flag;
            3'b111:  w_taken = !bus.ltu_flag;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_RST:    w_next = c_ST_FETCH;
            c_ST_FETCH:  if (w_rdy) w_next = c_ST_DECODE;
            c_ST_DECODE: begin
                case (bus.opcode)
                    c_OP_LOAD, c_OP_STORE: w_next = c_ST_MEMADR;
                    c_OP_R:     w_next = c_ST_EXR;
                    c_OP_I:     w_next = c_ST_EXI;
                    c_OP_BR:    w_next = c_ST_BR;
                    c_OP_JAL:   w_next = c_ST_JAL;
                    c_OP_JALR:  w_next = c_ST_JALR;
                    c_OP_LUI:   w_next = c_ST_LUI;
                    c_OP_AUIPC: w_next = c_ST_AUIPC;
`ifdef MC_CTRL_TRAP_EN
                    default:    w_next = c_ST_HALT;
`else
                    default:    w_next = c_ST_FETCH;
`endif
                endcase
            end
            c_ST_MEMADR: w_next = (bus.opcode == c_OP_STORE) ? c_ST_MEMWR : c_ST_MEMRD;
            c_ST_MEMRD:  if (w_rdy) w_next = c_ST_MEMWB;
            c_ST_MEMWB:  w_next = c_ST_FETCH;
            c_ST_MEMWR:  if (w_rdy) w_next = c_ST_FETCH;
            c_ST_EXR, c_ST_EXI, c_ST_JAL, c_ST_JALR2, c_ST_LUI, c_ST_AUIPC:
                         w_next = c_ST_ALUWB;
            c_ST_ALUWB:  w_next = c_ST_FETCH;
            c_ST_BR:     w_next = c_ST_FETCH;
            c_ST_JALR:   w_next = c_ST_JALR2;
            c_ST_HALT:   w_next = c_ST_HALT;
            default:     w_next = c_ST_RST;
        endcase
        if (w_tmo) w_next = c_ST_HALT;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Leaving a memory state clears the count, so every access starts at zero
            if ((MEM_TIMEOUT != 0) && w_mem_st && !w_rdy && !w_tmo)
                r_cnt <= r_cnt + c_CW'(1);
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_src_a  = c_SA_PC;
        w_alu_src_b  = c_SB_RD2;
        w_result_src = c_RS_ALUOUT;
        w_imm_src    = c_IMM_I;
        w_alu_ctrl   = c_ALU_ADD;
        case (r_state)
            c_ST_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = c_SB_FOUR;
                w_result_src = c_RS_ALURES;
                w_pc_write   = w_rdy;
                w_ir_write   = w_rdy;
            end
            c_ST_DECODE: begin
                w_alu_src_a = c_SA_OLD;
                w_alu_src_b = c_SB_IMM;
                w_imm_src   = c_IMM_B;
            end
            c_ST_MEMADR: begin
                w_alu_src_a = c_SA_A;
                w_alu_src_b = c_SB_IMM;
                w_imm_src   = (bus.opcode == c_OP_STORE) ? c_IMM_S : c_IMM_I;
            end
            c_ST_MEMRD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            c_ST_MEMWB: begin
                w_result_src = c_RS_DATA;
                w_reg_write  = 1'b1;
            end
            c_ST_MEMWR: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = w_rdy;
            end
            c_ST_EXR: begin
                w_alu_src_a = c_SA_A;
                w_alu_ctrl  = f_alu_op(bus.funct3, bus.funct7_5);
            end
            c_ST_EXI: begin
                w_alu_src_a = c_SA_A;
                w_alu_src_b = c_SB_IMM;
                w_alu_ctrl  = f_alu_op(bus.funct3, bus.funct7_5 && (bus.funct3 == 3'b101));
            end
            c_ST_ALUWB: w_reg_write = 1'b1;
            c_ST_BR: begin
                w_alu_src_a = c_SA_A;
                w_alu_ctrl  = c_ALU_SUB;
                w_pc_write  = w_taken;
            end
            c_ST_JAL, c_ST_JALR2: begin
                w_alu_src_a = c_SA_OLD;
                w_alu_src_b = c_SB_FOUR;
                w_pc_write  = 1'b1;
            end
            c_ST_JALR: begin
                w_alu_src_a = c_SA_A;
                w_alu_src_b = c_SB_IMM;
            end
            c_ST_LUI: begin
                w_alu_src_a = c_SA_ZERO;
                w_alu_src_b = c_SB_IMM;
                w_imm_src   = c_IMM_U;
            end
            c_ST_AUIPC: begin
                w_alu_src_a = c_SA_OLD;
                w_alu_src_b = c_SB_IMM;
                w_imm_src   = c_IMM_U;
            end
            default: ;
        endcase
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.pc_write   = w_pc_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.mem_write  = w_mem_write;
    assign bus.adr_src    = w_adr_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.result_src = w_result_src;
    assign bus.imm_src    = w_imm_src;
    assign bus.alu_ctrl   = w_alu_ctrl;
    assign bus.halted     = (r_state == c_ST_HALT);
endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Randomized instruction-stream bench for mc_ctrl_fsm with an
//            instruction-level reference model (phase plans per opcode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;
    localparam int c_TMO = 4;

    typedef enum int {P_RST, P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB, P_MWR, P_EXR, P_EXI,
                      P_AWB, P_BR, P_JAL, P_JALR, P_JALR2, P_LUI, P_AUIPC, P_HALT} phase_t;

    typedef struct packed {
        logic       mem_req, pc_write, ir_write, reg_write, mem_write, adr_src;
        logic [1:0] src_a, src_b, res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       halted;
    } ctrl_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ALUCTRL_W(4)) bus ();

    mc_ctrl_fsm #(
        .MEM_HANDSHAKE(1),
        .MEM_TIMEOUT  (c_TMO),
        .ALUCTRL_W    (4)
    ) u_dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int     n_vec = 0;
    int     n_err = 0;
    phase_t m_phase = P_RST;
    phase_t m_plan[$];
    int     m_wait = 0;
    int     m_delay = 0;
    int     force_delay = -1;
    int     force_zero = -1;
    logic [6:0] nx_opc = 7'b0110011;
    logic [2:0] nx_f3  = 3'b000;
    logic       nx_f7  = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c = {bus.mem_req, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.adr_src,
             bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src, bus.alu_ctrl, bus.halted};
        return c;
    endfunction

    // add sll slt sltu xor srl or and, indexed by funct3
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        logic base;
        case (f3[2:1])
            2'b00:   base = z;
            2'b10:   base = lt;
            2'b11:   base = ltu;
            default: return 1'b0;
        endcase
        return base ^ f3[0];
    endfunction

    function automatic ctrl_t exp_ctrl(input phase_t p);
        ctrl_t e;
        e = '0;
        case (p)
            P_FETCH: begin e.mem_req = 1; e.src_b = 2; e.res = 2;
                           e.pc_write = bus.mem_rdy; e.ir_write = bus.mem_rdy; end
            P_DEC:   begin e.src_a = 1; e.src_b = 1; e.imm = 3'd2; end
            P_MADR:  begin e.src_a = 2; e.src_b = 1; e.imm = (bus.opcode == 7'b0100011) ? 3'd1 : 3'd0; end
            P_MRD:   begin e.mem_req = 1; e.adr_src = 1; end
            P_MWB:   begin e.res = 1; e.reg_write = 1; end
            P_MWR:   begin e.mem_req = 1; e.adr_src = 1; e.mem_write = bus.mem_rdy; end
            P_EXR:   begin e.src_a = 2; e.alu = alu_of(bus.funct3, bus.funct7_5); end
            P_EXI:   begin e.src_a = 2; e.src_b = 1;
                           e.alu = alu_of(bus.funct3, bus.funct7_5 && bus.funct3 == 3'd5); end
            P_AWB:   e.reg_write = 1;
            P_BR:    begin e.src_a = 2; e.alu = 4'd1;
                           e.pc_write = br_taken(bus.funct3, bus.zero_flag, bus.lt_flag, bus.ltu_flag); end
            P_JAL, P_JALR2: begin e.src_a = 1; e.src_b = 2; e.pc_write = 1; end
            P_JALR:  begin e.src_a = 2; e.src_b = 1; end
            P_LUI:   begin e.src_a = 3; e.src_b = 1; e.imm = 3'd4; end
            P_AUIPC: begin e.src_a = 1; e.src_b = 1; e.imm = 3'd4; end
            P_HALT:  e.halted = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic is_mem(input phase_t p);
        return (p == P_FETCH) || (p == P_MRD) || (p == P_MWR);
    endfunction

    task automatic enter(input phase_t p);
        m_phase = p;
        m_wait  = 0;
        m_delay = (force_delay >= 0) ? force_delay : $urandom_range(0, c_TMO - 1);
    endtask

    // Phases after FETCH for one instruction, straight from the opcode table
    task automatic build_plan(input logic [6:0] opc);
        m_plan.delete();
        m_plan.push_back(P_DEC);
        case (opc)
            7'b0000011: begin m_plan.push_back(P_MADR); m_plan.push_back(P_MRD); m_plan.push_back(P_MWB); end
            7'b0100011: begin m_plan.push_back(P_MADR); m_plan.push_back(P_MWR); end
            7'b0110011: begin m_plan.push_back(P_EXR); m_plan.push_back(P_AWB); end
            7'b0010011: begin m_plan.push_back(P_EXI); m_plan.push_back(P_AWB); end
            7'b1100011: m_plan.push_back(P_BR);
            7'b1101111: begin m_plan.push_back(P_JAL); m_plan.push_back(P_AWB); end
            7'b1100111: begin m_plan.push_back(P_JALR); m_plan.push_back(P_JALR2); m_plan.push_back(P_AWB); end
            7'b0110111: begin m_plan.push_back(P_LUI); m_plan.push_back(P_AWB); end
            7'b0010111: begin m_plan.push_back(P_AUIPC); m_plan.push_back(P_AWB); end
            default: begin
`ifdef MC_CTRL_TRAP_EN
                m_plan.push_back(P_HALT);
`endif
            end
        endcase
    endtask

    task automatic advance(input logic rdy);
        if (m_phase == P_HALT) return;
        if (m_phase == P_RST) enter(P_FETCH);
        else if (is_mem(m_phase) && !rdy) begin
            if (m_wait == c_TMO - 1) enter(P_HALT);
            else m_wait++;
        end else begin
            if (m_phase == P_FETCH) build_plan(bus.opcode);
            if (m_plan.size() == 0) enter(P_FETCH);
            else enter(m_plan.pop_front());
        end
    endtask

    task automatic step();
        logic  rdy;
        ctrl_t got, exp;
        @(posedge clk);
        #1;
        if (m_phase == P_FETCH) begin
            bus.opcode   = nx_opc;
            bus.funct3   = nx_f3;
            bus.funct7_5 = nx_f7;
        end
        rdy = is_mem(m_phase) ? (m_wait >= m_delay) : 1'($urandom);
        bus.mem_rdy   = rdy;
        bus.zero_flag = (force_zero >= 0) ? force_zero[0] : 1'($urandom);
        bus.lt_flag   = 1'($urandom);
        bus.ltu_flag  = 1'($urandom);
        #4;
        got = dut_ctrl();
        exp = exp_ctrl(m_phase);
        chk_eq(m_phase.name(), {12'b0, got}, {12'b0, exp});
        advance(rdy);
    endtask

    task automatic run_instr();
        bit seen = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (m_phase == P_HALT) return;
            if (m_phase != P_FETCH) seen = 1;
            else if (seen) return;
        end
        chk_eq("instr_budget", 32'd0, 32'd1);
    endtask

    task automatic set_nx(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        nx_opc = o; nx_f3 = f3; nx_f7 = f7;
    endtask

    task automatic do_reset();
        ctrl_t got;
        rstn = 1'b0;
        m_phase = P_RST;
        m_plan.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        bus.mem_rdy = 1'b1;
        #4;
        got = dut_ctrl();
        chk_eq("RST", {12'b0, got}, {12'b0, exp_ctrl(P_RST)});
        enter(P_FETCH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [9];
        ctrl_t got;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;
        bus.zero_flag = 1'b0; bus.lt_flag = 1'b0; bus.ltu_flag = 1'b0; bus.mem_rdy = 1'b0;

        #12;
        got = dut_ctrl();
        chk_eq("in_reset", {12'b0, got}, 32'd0);
        do_reset();

        // add x3,x1,x2
        force_delay = 0;
        set_nx(7'b0110011, 3'b000, 1'b0); run_instr();
        // sub and srai to cover funct7_5 handling
        set_nx(7'b0110011, 3'b000, 1'b1); run_instr();
        set_nx(7'b0010011, 3'b000, 1'b1); run_instr();
        set_nx(7'b0010011, 3'b101, 1'b1); run_instr();
        // lw with three stall cycles in FETCH and MEMRD
        force_delay = 3;
        set_nx(7'b0000011, 3'b010, 1'b0); run_instr();
        // bne not taken / taken, then bltu
        force_delay = 0;
        set_nx(7'b1100011, 3'b001, 1'b0);
        force_zero = 1; run_instr();
        force_zero = 0; run_instr();
        force_zero = -1;
        set_nx(7'b1100011, 3'b110, 1'b0); repeat (4) run_instr();

        force_delay = -1;
        repeat (150) begin
            set_nx(ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom));
            run_instr();
        end

        // reset asserted in the middle of a load's MEMRD wait
        force_delay = 3;
        set_nx(7'b0000011, 3'b010, 1'b0);
        for (int n = 0; n < 30 && m_phase != P_MRD; n++) step();
        step();
        @(posedge clk);
        #1 bus.mem_rdy = 1'b0;
        #1 rstn = 1'b0;
        #1;
        got = dut_ctrl();
        chk_eq("rst_async", {12'b0, got}, 32'd0);
        do_reset();

        // ready on the last allowed wait cycle completes the access
        force_delay = c_TMO - 1;
        set_nx(7'b0110011, 3'b100, 1'b0); run_instr();
        // no ready at all: halts and stays halted
        force_delay = 99;
        run_instr();
        repeat (4) step();
        do_reset();

        // unknown opcode: NOP or trap depending on build
        force_delay = 0;
        set_nx(7'h7F, 3'b000, 1'b0); run_instr();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
